// File: rtl/cic_pkg.sv
// Shared types and defaults for the CIC decimator controller.
// State encodings, parameter defaults and a register width helper.
package cic_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    WARMUP = 2'd2,
    RUN    = 2'd3
  } state_t;

  localparam int STAGES_DEF     = 2;
  localparam int MAX_LOG2_R_DEF = 4;
  localparam int WIDTH_DEF      = 5;

  // Integrator/comb register width needed to avoid overflow.
  function automatic int cic_reg_width(
    input int stages,
    input int max_log2_r
  );
    return 1 + stages * max_log2_r;
  endfunction

endpackage

// File: rtl/cic_out_reg.sv
// One-entry valid/ready holding register for decimated samples.
// Drops a new sample when full and not drained, flagging overrun.
module cic_out_reg
  import cic_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             cap,
  input  logic [WIDTH-1:0] din,
  input  logic             ready,
  input  logic             clr_ovr,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             overrun
);

  logic drain;
  logic drop;

  assign drain = valid && ready;
  assign drop  = cap && valid && !ready;

  // Sample holding register with flush on a fresh run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (cap && (!valid || ready)) begin
      data  <= din;
      valid <= 1'b1;
    end else if (!cap && drain) begin
      valid <= 1'b0;
    end
  end

  // Sticky overrun flag; a new drop beats a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end else if (clr_ovr) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: rtl/cic_decim_ctrl.sv
// CIC decimator sequencer: clear, warm-up, run with comb strobe.
// Single clock domain; comb_en pulses once every 2^r_lat cycles.
module cic_decim_ctrl
  import cic_pkg::*;
#(
  parameter int STAGES     = STAGES_DEF,
  parameter int MAX_LOG2_R = MAX_LOG2_R_DEF,
  parameter int WIDTH      = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [2:0]       ratio_log2,
  input  logic             clr_overrun,
  input  logic [WIDTH-1:0] comb_data,
  output logic             integ_clr,
  output logic             integ_en,
  output logic             comb_en,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overrun
);

  localparam int RW  = $clog2(MAX_LOG2_R + 1);
  localparam int WW  = $clog2(STAGES + 1);
  localparam int PW1 = MAX_LOG2_R + 1;

  state_t                state;
  state_t                state_nxt;
  logic [MAX_LOG2_R-1:0] phase;
  logic [WW-1:0]         warm;
  logic [RW-1:0]         r_lat;
  logic [MAX_LOG2_R:0]   mask;
  logic                  active;
  logic                  term;
  logic                  accept;
  logic                  warm_done;
  logic                  cap;

  assign active    = (state == WARMUP) || (state == RUN);
  assign mask      = (PW1'(1) << r_lat) - PW1'(1);
  assign term      = ({1'b0, phase} == mask);
  assign comb_en   = active && term;
  assign integ_en  = active;
  assign integ_clr = (state == CLEAR);
  assign busy      = (state != IDLE);
  assign accept    = (state == IDLE) && start && !stop;
  assign warm_done = (warm == WW'(STAGES - 1));
  assign cap       = comb_en && (state == RUN);

  // Next-state logic; stop always returns to IDLE.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (accept) state_nxt = CLEAR;
      end
      CLEAR: begin
        state_nxt = stop ? IDLE : WARMUP;
      end
      WARMUP: begin
        if (stop)
          state_nxt = IDLE;
        else if (comb_en && warm_done)
          state_nxt = RUN;
      end
      RUN: begin
        if (stop) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Ratio latch, phase counter and saturating warm-up count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lat <= '0;
      phase <= '0;
      warm  <= '0;
    end else begin
      if (accept) begin
        if (int'(ratio_log2) > MAX_LOG2_R)
          r_lat <= RW'(MAX_LOG2_R);
        else
          r_lat <= RW'(ratio_log2);
      end
      if (state == CLEAR) begin
        phase <= '0;
        warm  <= '0;
      end else if (active) begin
        phase <= term ? '0 : phase + 1'b1;
        if (comb_en && (state == WARMUP)
            && (warm != WW'(STAGES)))
          warm <= warm + 1'b1;
      end
    end
  end

  cic_out_reg #(
    .WIDTH (WIDTH)
  ) u_out (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (integ_clr),
    .cap     (cap),
    .din     (comb_data),
    .ready   (out_ready),
    .clr_ovr (clr_overrun),
    .data    (out_data),
    .valid   (out_valid),
    .overrun (overrun)
  );

endmodule
